// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and flag-vector layout
// used by the ALU arbiter and its response buffer.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;

    localparam int FLG_C  = 0;
    localparam int FLG_Z  = 1;
    localparam int FLG_N  = 2;
    localparam int FLG_V  = 3;
    localparam int FLAG_W = 4;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after
// ptr (wrapping), returned one-hot and as an encoded index.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU among NUM_REQ requesters,
// with a single-entry tagged response buffer. Define ALU_ARB_LOCK_EN for req_lock.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*8-1:0] req_a,
    input  logic [NUM_REQ*8-1:0] req_b,
    input  logic [NUM_REQ*3-1:0] req_op,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]   req_lock,
`endif
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [2:0]           alu_opcode,
    input  logic [7:0]           alu_result,
    input  logic                 alu_carry,
    input  logic                 alu_zero,
    input  logic                 alu_negative,
    input  logic                 alu_overflow,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_result,
    output logic [FLAG_W-1:0]    rsp_flags
);

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [7:0]        rsp_result_q, rsp_result_d;
    logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic               can_accept;
    logic               xfer;
    logic               hold_ptr;
    logic [ID_W-1:0]    ptr_nxt;
    logic [FLAG_W-1:0]  flags_in;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign can_accept = ~rsp_valid_q | rsp_ready;
    assign req_ready  = gnt & {NUM_REQ{can_accept & ~rst}};
    assign xfer       = gnt_any & can_accept & ~rst;

    // Winner's operands reach the ALU even while the buffer is stalled
    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                alu_a      = req_a[i*8 +: 8];
                alu_b      = req_b[i*8 +: 8];
                alu_opcode = req_op[i*3 +: 3];
            end
        end
    end

    always_comb begin
        flags_in        = '0;
        flags_in[FLG_C] = alu_carry;
        flags_in[FLG_Z] = alu_zero;
        flags_in[FLG_N] = alu_negative;
        flags_in[FLG_V] = alu_overflow;
    end

`ifdef ALU_ARB_LOCK_EN
    assign hold_ptr = req_lock[gnt_idx];
`else
    assign hold_ptr = 1'b0;
`endif

    always_comb begin
        ptr_nxt = gnt_idx + 1'b1;
        if (gnt_idx == ID_W'(NUM_REQ - 1)) ptr_nxt = '0;
        if (hold_ptr) ptr_nxt = gnt_idx;
    end

    always_comb begin
        ptr_d        = ptr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        if (xfer) begin
            ptr_d        = ptr_nxt;
            rsp_valid_d  = 1'b1;
            rsp_id_d     = gnt_idx;
            rsp_result_d = alu_result;
            rsp_flags_d  = flags_in;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Round-robin arbiter and response buffer sharing one ALU_8bit_flags instance among NUM_REQ requesters.
- Each requester presents operands and opcode with a valid/ready handshake.
- The winner's operands drive the ALU combinationally. Result and flags are registered into a single-entry response buffer, tagged with the requester ID.
- Sits between the requesting control blocks and the ALU; the ALU is instantiated beside this block, not inside it.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ), width of rsp_id. Derived localparam; not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  NUM_REQ*8  operand A; requester i occupies [8i+7:8i].
- req_b  in  NUM_REQ*8  operand B; same slicing as req_a.
- req_op  in  NUM_REQ*3  opcode; requester i occupies [3i+2:3i].
- alu_a  out  8  to ALU A.
- alu_b  out  8  to ALU B.
- alu_opcode  out  3  to ALU opcode.
- alu_result  in  8  from ALU.
- alu_carry, alu_zero, alu_negative, alu_overflow  in  1 each  ALU flags.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer accept.
- rsp_id  out  ID_W  index of the requester that produced the response.
- rsp_result  out  8  registered ALU result.
- rsp_flags  out  4  registered flags, packed {overflow, negative, zero, carry}.

Behaviour:
- Reset (synchronous, rst=1):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, round-robin pointer ptr=0.
  - Any held response is discarded.
  - req_ready=0 while rst=1.
- Buffer state:
  - EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
  - can_accept = ~rsp_valid | rsp_ready.
- Grant (combinational):
  - Scan req_valid starting at index ptr, wrapping modulo NUM_REQ.
  - The first valid index g is the winner.
  - req_ready[g] = can_accept & ~rst. All other bits are 0.
- ALU drive:
  - alu_a, alu_b and alu_opcode carry the winner's slices whenever any req_valid is high, independent of can_accept.
  - With no valid requester, they are all zero.
  - Opcodes pass through unmodified; encoding is owned by the ALU (000 ADD, 001 SUB, 010 AND).
- Transfer: req_valid[g] & req_ready[g]. At the next edge:
  - rsp_result<=alu_result, rsp_flags<=packed flags, rsp_id<=g, rsp_valid<=1.
  - ptr<=(g+1) mod NUM_REQ.
  - Latency from accept edge to rsp_valid: 1 cycle.
- Response hold:
  - While rsp_valid & ~rsp_ready, all rsp_* outputs are stable and no req_ready is asserted.
  - On rsp_ready with no simultaneous transfer: rsp_valid<=0.
  - On rsp_ready with a simultaneous transfer: the buffer reloads with no bubble, giving full throughput of 1 op/cycle.
- Requester obligation: while req_valid[i] & ~req_ready[i], slices and valid are held stable. The bench checks this; the DUT does not.
- Fairness:
  - A continuously valid requester is granted within NUM_REQ transfers.
  - ptr changes only on a transfer.
- Boundaries:
  - No valid requests: ptr unchanged, buffer drains normally.
  - All requests valid: strict rotation.
  - ptr=NUM_REQ-1 wraps to 0.
  - Reset asserted in the same cycle as a transfer: reset wins and no response is produced.

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- When defined:
  - Adds port req_lock  in  NUM_REQ.
  - If the transferring requester g has req_lock[g]=1, ptr<=g instead of g+1. This gives back-to-back priority for multi-op sequences.
  - Deasserting req_lock[g] on a transfer resumes normal rotation.
- When undefined: no port; behaviour as above.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010.
  - Flag bit indices FLG_C=0, FLG_Z=1, FLG_N=2, FLG_V=3.
  - Flag-vector width constant 4.
- One natural sub-module, rr_pick: combinational round-robin priority picker. Inputs req vector and ptr; outputs one-hot grant plus encoded index.

Test Plan:
- Req0 A=10, B=5, op=000, rsp_ready=1 → accept cycle 0; cycle 1: rsp_valid=1, id=0, result=15, flags=4'b0000.
- Req1 A=120, B=120, op=000 → result=8'hF0, flags=4'b1100 (V=1, N=1, Z=0, C=0), id=1.
- Req2 A=10, B=10, op=001 → result=0, zero=1, negative=0, overflow=0, id=2.
- All 4 valid continuously, ptr=0, rsp_ready=1 → rsp_id sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
- Response FULL, rsp_ready=0 for 3 cycles with req0 valid → req_ready=0 throughout, rsp_* stable; rsp_ready=1 → same-cycle accept, new response next cycle.
- rst pulsed while rsp_valid=1 → next cycle rsp_valid=0, all rsp_*=0, next grant starts at index 0. With ALU_ARB_LOCK_EN: req_lock[1]=1 and req1/req2 valid → id 1 granted repeatedly until lock drops.
